cnn_tile_feeder: RTL and testbench
==================================

Name: cnn_tile_feeder

Overview:
- Host-side driver for the CNN classifier core.
- Accepts a row-major stream of 8-bit pixels forming one 5x5 tile, plus tile coordinates, and packs them into the 200-bit image bus.
- Starts the core, waits for its completion, and returns the 4-bit class result with the tile coordinates on a valid/ready result port.
- Sits between the image-memory scanner and the CNN core: the initiator side of the core's START/DONE interface.

Parameters:
- PIX_W, 8, pixel width in bits.
- TILE_N, 25, pixels per tile (5x5).
- TIMEOUT, 1024, maximum cycles in WAIT before an error result is reported.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- PIX_VALID  input  1  pixel stream valid.
- PIX_READY  output  1  feeder can accept a pixel.
- PIX_DATA  input  8  pixel value.
- TILE_X  input  5  tile column; sampled with pixel 0.
- TILE_Y  input  5  tile row; sampled with pixel 0.
- START  output  1  one-cycle start pulse to the CNN core.
- X  output  5  tile column to the core.
- Y  output  5  tile row to the core.
- IMGIN  output  200  packed tile to the core.
- DONE  input  1  core completion.
- OUT  input  4  core class result.
- RES_VALID  output  1  result available.
- RES_READY  input  1  consumer accepts result.
- RES_CLASS  output  4  class result.
- RES_X  output  5  tile column of the result.
- RES_Y  output  5  tile row of the result.
- RES_ERR  output  1  result is a timeout error.
- BUSY  output  1  high in any state except LOAD with a pixel count of 0.

Behaviour:
- Reset (asynchronous, nRST low): state=LOAD, pixel count=0, timeout counter=0. PIX_READY=1, START=0, X=0, Y=0, IMGIN=0, RES_VALID=0, RES_CLASS=0, RES_X=0, RES_Y=0, RES_ERR=0, BUSY=0. Reset mid-operation drops any partial tile or pending result; no START is issued after reset release until a full new tile has loaded.
- States:
  - LOAD: PIX_READY=1. Each PIX_VALID&PIX_READY cycle writes PIX_DATA to IMGIN[8k+7:8k], where k is the pixel count (0..24), then increments the count. When k=0, TILE_X/TILE_Y are latched into X/Y. The handshake at k=24 moves to ISSUE on the next edge and clears the count. IMGIN bytes not yet written keep their previous values.
  - ISSUE: PIX_READY=0. START=1 for exactly this one cycle. Go to WAIT and clear the timeout counter.
  - WAIT: PIX_READY=0; X/Y/IMGIN held stable. DONE is sampled only in this state.
    - DONE=1: capture OUT into RES_CLASS, X/Y into RES_X/RES_Y, set RES_ERR=0, go to REPORT.
    - DONE=0: increment the counter; when the count reaches TIMEOUT-1 without DONE, set RES_CLASS=0, RES_ERR=1, RES_X/RES_Y=X/Y, go to REPORT.
    - DONE and timeout in the same cycle: DONE wins (RES_ERR=0).
  - REPORT: RES_VALID=1; RES_* held stable until RES_VALID&RES_READY. On that cycle go to LOAD; RES_VALID drops on the next edge. PIX_READY=0 throughout REPORT.
- DONE asserted in LOAD, ISSUE or REPORT is ignored.
- Latency:
  - The last pixel handshake at edge n produces START=1 in cycle n+1.
  - DONE sampled at edge m produces RES_VALID=1 from edge m onward.
  - The earliest next pixel is accepted one cycle after the result handshake.
- Timeout counter width is clog2(TIMEOUT); it saturates and does not wrap.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package/header holds the state encoding, PIX_W, TILE_N, the 5-bit coordinate width, the 4-bit class width, and the packing macro (pixel k at bits 8k+7:8k). This macro is shared with the CNN core.
- Single module. Optional sub-module cnn_result_reg (valid/ready holding register for RES_*).

Test Plan:
- Reset values: assert nRST=0 mid-LOAD after 10 pixels, release, then stream 25 pixels 0x01..0x19 at TILE_X=3, TILE_Y=7 -> a single START pulse; IMGIN[7:0]=0x01, IMGIN[199:192]=0x19; X=3, Y=7.
- Basic round trip: core model returns DONE with OUT=4'd9 after 6 cycles, RES_READY=1 -> RES_VALID for one cycle with RES_CLASS=9, RES_X=3, RES_Y=7, RES_ERR=0.
- Backpressure: RES_READY=0 for 20 cycles -> RES_* stable, PIX_READY=0 with PIX_VALID=1 (no pixel consumed); RES_READY=1 -> the next tile's pixel 0 is accepted one cycle later.
- Timeout: TIMEOUT=16, DONE never asserted -> RES_VALID after 16 WAIT cycles with RES_ERR=1, RES_CLASS=0.
- DONE at the timeout cycle: DONE=1 in WAIT cycle 15 with OUT=4'd2 -> RES_ERR=0, RES_CLASS=2.
- Spurious DONE: DONE=1 during LOAD and ISSUE -> no state change, no RES_VALID, START still exactly one cycle.

Source files
------------

// File: rtl/cnn_tile_feeder_pkg.sv
// Shared types for the CNN tile feeder and the CNN core it drives.
// Image-bus packing places pixel k at bits [8k+7:8k].
`ifndef CNN_TILE_FEEDER_PKG_SV
`define CNN_TILE_FEEDER_PKG_SV

// Low bit of pixel k on the image bus; k must be a 5-bit pixel index.
`define CNN_PIX_LSB(k) ({(k), 3'b000})

package cnn_tile_feeder_pkg;

  localparam int PIX_W   = 8;
  localparam int TILE_N  = 25;
  localparam int COORD_W = 5;
  localparam int CLASS_W = 4;
  localparam int CNT_W   = 5;
  localparam int IMG_W   = PIX_W * TILE_N;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CLASS_W-1:0] class_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  typedef struct packed {
    logic   err;
    coord_t y;
    coord_t x;
    class_t cls;
  } res_t;

endpackage

`endif

// File: rtl/cnn_result_reg.sv
// Valid/ready holding register for one classification result.
// Loads in one cycle; contents stay frozen while res_vld is high and res_rdy is low.
module cnn_result_reg
  import cnn_tile_feeder_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic load,
  input  res_t ld_dat,
  input  logic res_rdy,
  output logic res_vld,
  output res_t res_dat
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      res_vld <= 1'b0;
      res_dat <= '0;
    end else if (load) begin
      res_vld <= 1'b1;
      res_dat <= ld_dat;
    end else if (res_vld && res_rdy) begin
      res_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/cnn_tile_feeder.sv
// Packs a 25-pixel tile onto the core image bus, pulses START, waits for DONE or timeout.
// Latency: last pixel -> START next cycle; DONE -> RES_VALID same edge. Result held until RES_READY.
// Backpressure: PIX_READY only in LOAD, so pixels stall from the last pixel until the result is taken.
module cnn_tile_feeder
  import cnn_tile_feeder_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               PIX_VALID,
  output logic               PIX_READY,
  input  logic [PIX_W-1:0]   PIX_DATA,
  input  logic [COORD_W-1:0] TILE_X,
  input  logic [COORD_W-1:0] TILE_Y,
  output logic               START,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [IMG_W-1:0]   IMGIN,
  input  logic               DONE,
  input  logic [CLASS_W-1:0] OUT,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [CLASS_W-1:0] RES_CLASS,
  output logic [COORD_W-1:0] RES_X,
  output logic [COORD_W-1:0] RES_Y,
  output logic               RES_ERR,
  output logic               BUSY
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(TILE_N - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [IMG_W-1:0]   imgin_d;
  coord_t             x_d, y_d;
  logic               pix_ready_d, start_d, busy_d;
  logic               pix_hs, res_hs;
  logic               res_load;
  res_t               res_ld_dat, res_dat;

  // PIX_READY is a registered copy of "state is LOAD", so it qualifies the handshake directly.
  assign pix_hs = PIX_VALID & PIX_READY;
  assign res_hs = RES_VALID & RES_READY;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_LOAD;
      pix_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    tmo_d      = tmo_q;
    imgin_d    = IMGIN;
    x_d        = X;
    y_d        = Y;
    res_load   = 1'b0;
    res_ld_dat = '{err: 1'b0, y: Y, x: X, cls: OUT};

    case (state_q)
      ST_LOAD: begin
        if (pix_hs) begin
          imgin_d[`CNN_PIX_LSB(pix_cnt_q) +: PIX_W] = PIX_DATA;
          if (pix_cnt_q == '0) begin
            x_d = TILE_X;
            y_d = TILE_Y;
          end
          if (pix_cnt_q == PIX_LAST) begin
            state_d   = ST_ISSUE;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        // DONE takes priority over a timeout landing in the same cycle.
        if (DONE) begin
          res_load = 1'b1;
          state_d  = ST_REPORT;
        end else if (tmo_q == TMO_LAST) begin
          res_load       = 1'b1;
          res_ld_dat.err = 1'b1;
          res_ld_dat.cls = '0;
          state_d        = ST_REPORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_REPORT: begin
        if (res_hs) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase

    pix_ready_d = (state_d == ST_LOAD);
    start_d     = (state_d == ST_ISSUE);
    busy_d      = !((state_d == ST_LOAD) && (pix_cnt_d == '0));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      PIX_READY <= 1'b1;
      START     <= 1'b0;
      X         <= '0;
      Y         <= '0;
      IMGIN     <= '0;
      BUSY      <= 1'b0;
    end else begin
      PIX_READY <= pix_ready_d;
      START     <= start_d;
      X         <= x_d;
      Y         <= y_d;
      IMGIN     <= imgin_d;
      BUSY      <= busy_d;
    end
  end

  cnn_result_reg u_res (
    .CLK     (CLK),
    .nRST    (nRST),
    .load    (res_load),
    .ld_dat  (res_ld_dat),
    .res_rdy (RES_READY),
    .res_vld (RES_VALID),
    .res_dat (res_dat)
  );

  assign RES_CLASS = res_dat.cls;
  assign RES_X     = res_dat.x;
  assign RES_Y     = res_dat.y;
  assign RES_ERR   = res_dat.err;

endmodule

// File: tb/tb_cnn_tile_feeder.sv
// Directed/random bench for cnn_tile_feeder against an array-based tile model.
module tb_cnn_tile_feeder;

  localparam int TO = 16;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         PIX_VALID;
  logic         PIX_READY;
  logic [7:0]   PIX_DATA;
  logic [4:0]   TILE_X, TILE_Y;
  logic         START;
  logic [4:0]   X, Y;
  logic [199:0] IMGIN;
  logic         DONE;
  logic [3:0]   OUT;
  logic         RES_VALID;
  logic         RES_READY;
  logic [3:0]   RES_CLASS;
  logic [4:0]   RES_X, RES_Y;
  logic         RES_ERR;
  logic         BUSY;

  always #5 CLK = ~CLK;

  cnn_tile_feeder #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA),
    .TILE_X(TILE_X), .TILE_Y(TILE_Y),
    .START(START), .X(X), .Y(Y), .IMGIN(IMGIN),
    .DONE(DONE), .OUT(OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_CLASS(RES_CLASS), .RES_X(RES_X), .RES_Y(RES_Y), .RES_ERR(RES_ERR),
    .BUSY(BUSY)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [7:0] img_m [25];

  always @(negedge CLK) if (START === 1'b1) start_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [199:0] model_img();
    logic [199:0] r;
    r = '0;
    for (int k = 0; k < 25; k++) r[k*8 +: 8] = img_m[k];
    return r;
  endfunction

  // mode 0: pixels k+1; mode 1: random pixels with random idle gaps.
  // d: WAIT cycle in which DONE is raised (<0 or >=TO means never).
  task automatic run_tile(input logic [4:0] tx, input logic [4:0] ty, input int mode,
                          input int d, input logic [3:0] cls, input int rdy_delay, input bit spur);
    logic [7:0] pix [25];
    int base, guard, exp_c;
    bit exp_err;
    logic [3:0] exp_cls;
    for (int k = 0; k < 25; k++) pix[k] = (mode == 0) ? 8'(k + 1) : 8'($urandom);
    base = start_cnt;
    for (int k = 0; k < 25; k++) begin
      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        PIX_VALID = 1'b0; DONE = spur; OUT = 4'($urandom);
        step;
      end
      PIX_VALID = 1'b1;
      PIX_DATA  = pix[k];
      TILE_X    = (k == 0) ? tx : ~tx;
      TILE_Y    = (k == 0) ? ty : ~ty;
      DONE      = spur;
      OUT       = 4'($urandom);
      guard = 0;
      while (PIX_READY !== 1'b1 && guard < 64) begin step; guard++; end
      if (guard >= 64) begin
        n_assert++; n_fail++;
        $error("FAIL pix_ready_wait: observed %0b expected 1", PIX_READY);
      end
      step;
      img_m[k] = pix[k];
      if (k == 0)  check("busy_after_pix0", 200'(BUSY), 200'(1));
      if (k == 12) check("imgin_partial", IMGIN, model_img());
      if (k < 24)  check("no_early_start", 200'(start_cnt - base), 200'(0));
    end
    PIX_VALID = 1'b0;
    DONE      = spur;
    check("start_pulse", 200'(START), 200'(1));
    check("pix_ready_issue", 200'(PIX_READY), 200'(0));
    check("x_latched", 200'(X), 200'(tx));
    check("y_latched", 200'(Y), 200'(ty));
    check("imgin_full", IMGIN, model_img());
    step;
    check("start_dropped", 200'(START), 200'(0));
    check("start_count_issue", 200'(start_cnt - base), 200'(1));
    exp_err = !(d >= 0 && d < TO);
    exp_c   = exp_err ? TO - 1 : d;
    exp_cls = exp_err ? 4'd0 : cls;
    for (int c = 0; c <= exp_c; c++) begin
      DONE = (c == d);
      OUT  = (c == d) ? cls : 4'($urandom);
      step;
      if (c < exp_c) check("res_valid_wait", 200'(RES_VALID), 200'(0));
    end
    DONE = spur;
    check("res_valid", 200'(RES_VALID), 200'(1));
    check("res_class", 200'(RES_CLASS), 200'(exp_cls));
    check("res_x", 200'(RES_X), 200'(tx));
    check("res_y", 200'(RES_Y), 200'(ty));
    check("res_err", 200'(RES_ERR), 200'(exp_err));
    RES_READY = 1'b0;
    PIX_VALID = 1'b1;
    PIX_DATA  = 8'hEE;
    for (int i = 0; i < rdy_delay; i++) begin
      OUT = 4'($urandom);
      step;
      check("res_hold_valid", 200'(RES_VALID), 200'(1));
      check("res_hold_class", 200'(RES_CLASS), 200'(exp_cls));
      check("pix_stalled", 200'(PIX_READY), 200'(0));
    end
    RES_READY = 1'b1;
    step;
    RES_READY = 1'b0;
    PIX_VALID = 1'b0;
    DONE      = 1'b0;
    check("res_valid_drop", 200'(RES_VALID), 200'(0));
    check("pix_ready_back", 200'(PIX_READY), 200'(1));
    check("busy_idle", 200'(BUSY), 200'(0));
    check("start_count_end", 200'(start_cnt - base), 200'(1));
    check("imgin_held", IMGIN, model_img());
  endtask

  initial begin
    logic [199:0] img;
    nRST = 1'b0; PIX_VALID = 1'b0; PIX_DATA = '0; TILE_X = '0; TILE_Y = '0;
    DONE = 1'b0; OUT = '0; RES_READY = 1'b0;
    for (int k = 0; k < 25; k++) img_m[k] = 8'h00;
    repeat (3) step;
    nRST = 1'b1;
    step;

    // Partial tile then reset mid-LOAD.
    for (int k = 0; k < 10; k++) begin
      PIX_VALID = 1'b1; PIX_DATA = 8'hA0 + 8'(k); TILE_X = 5'd9; TILE_Y = 5'd9;
      step;
    end
    PIX_VALID = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("rst_pix_ready", 200'(PIX_READY), 200'(1));
    check("rst_start", 200'(START), 200'(0));
    check("rst_x", 200'(X), 200'(0));
    check("rst_y", 200'(Y), 200'(0));
    check("rst_imgin", IMGIN, 200'(0));
    check("rst_res_valid", 200'(RES_VALID), 200'(0));
    check("rst_res_class", 200'(RES_CLASS), 200'(0));
    check("rst_res_x", 200'(RES_X), 200'(0));
    check("rst_res_y", 200'(RES_Y), 200'(0));
    check("rst_res_err", 200'(RES_ERR), 200'(0));
    check("rst_busy", 200'(BUSY), 200'(0));
    step;
    nRST = 1'b1;
    step;

    run_tile(5'd3, 5'd7, 0, 6, 4'd9, 0, 1'b0);
    img = IMGIN;
    check("imgin_byte0", 200'(img[7:0]), 200'(8'h01));
    check("imgin_byte24", 200'(img[199:192]), 200'(8'h19));

    run_tile(5'd10, 5'd20, 1, 3, 4'($urandom), 20, 1'b0);   // result backpressure
    run_tile(5'd31, 5'd0, 1, -1, 4'd7, 2, 1'b0);            // timeout
    run_tile(5'd4, 5'd5, 1, TO - 1, 4'd2, 0, 1'b0);         // DONE on the timeout cycle
    run_tile(5'd12, 5'd13, 1, 0, 4'd5, 3, 1'b1);            // spurious DONE outside WAIT
    for (int i = 0; i < 4; i++)
      run_tile(5'($urandom), 5'($urandom), 1, $urandom_range(0, TO + 3) - 1,
               4'($urandom), $urandom_range(0, 3), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
